// File: rtl/core_pkg.sv
// Shared core constants and types: data/index widths, fixed register indices
// and the reset value of the stack pointer.
package core_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t REG_ZERO = reg_idx_t'(0);
  localparam reg_idx_t REG_SP   = reg_idx_t'(2);
  localparam word_t    SP_INIT  = 32'h0000_3FFC;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: forces zero for x0 and during
// reset, and forwards a same-cycle write-back to the reader.
module rf_read_port #(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int ADDR_W = core_pkg::ADDR_W
) (
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs,
  input  logic [DATA_W-1:0] stored,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data
);

  logic is_zero;
  logic bypass;

  assign is_zero = (rs == '0);
  assign bypass  = write_en && (rd == rs);

  always_comb begin
    read_data = stored;
    if (reset || is_zero) begin
      read_data = '0;
    end else if (bypass) begin
      read_data = write_data;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports with write-through
// bypass, one write-back port, x0 hard-wired to zero, x2 reset to SP_INIT.
module reg_file #(
  parameter int                DATA_W   = core_pkg::DATA_W,
  parameter int                NUM_REGS = core_pkg::NUM_REGS,
  parameter int                ADDR_W   = core_pkg::ADDR_W,
  parameter logic [DATA_W-1:0] SP_INIT  = core_pkg::SP_INIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] Rs1,
  input  logic [ADDR_W-1:0] Rs2,
  input  logic [ADDR_W-1:0] Rd,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  import core_pkg::*;

  // x0 has no storage; slot 0 of the read view is a constant zero.
  logic [DATA_W-1:0] regs     [1:NUM_REGS-1];
  logic [DATA_W-1:0] rd_view  [NUM_REGS];
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;
  logic              write_en;

  assign write_en = RegWrite && (Rd != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk) begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (reset) begin
        regs[i] <= (ADDR_W'(i) == ADDR_W'(REG_SP)) ? SP_INIT : '0;
      end else if (write_en && (Rd == ADDR_W'(i))) begin
        regs[i] <= WriteData;
      end
    end
  end

  assign rd_view[0] = '0;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_view
    assign rd_view[g] = regs[g];
  end

  assign stored1 = rd_view[Rs1];
  assign stored2 = rd_view[Rs2];

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port1 (
    .reset      (reset),
    .rs         (Rs1),
    .stored     (stored1),
    .write_en   (write_en),
    .rd         (Rd),
    .write_data (WriteData),
    .read_data  (ReadData1)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port2 (
    .reset      (reset),
    .rs         (Rs2),
    .stored     (stored2),
    .write_en   (write_en),
    .rd         (Rd),
    .write_data (WriteData),
    .read_data  (ReadData2)
  );

endmodule
